fifo_reader: RTL and testbench

Read-side consumer for the team's parameterised `fifo` block. It drains symbols from the FIFO's pop/out port, packs `SYMS` consecutive symbols of `SYM_W` bits into one word, and presents that word downstream on a valid/ready handshake. It sits between a FIFO instance and any wide-word consumer, and is the counterpart of the push-side producer.

---
 rtl/fifo_reader.sv | 100 ++++++++++
 tb/tb_fifo_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: packs SYMS popped FIFO symbols (first symbol in the LSBs) into one word; `FIFO_RD_PARITY_EN adds word_parity.
// Latency: 2 cycles per symbol (pop, capture); word_valid rises 2*SYMS cycles after the first pop.
// Backpressure: the word is held until word_ready; no pops while holding or while empty is high.
module fifo_reader #(
  parameter int SYM_W = 2,
  parameter int SYMS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [SYM_W-1:0]      data_in,
  output logic                  pop,
  output logic [SYM_W*SYMS-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready
`ifdef FIFO_RD_PARITY_EN
  ,
  output logic                  word_parity
`endif
);

  localparam int               IDX_W  = $clog2(SYMS);
  localparam int               WORD_W = SYM_W * SYMS;
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(SYMS - 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    CAPT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [WORD_W-1:0] acc, acc_nxt;
  logic              word_ld;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    acc_nxt    = acc;
    word_ld    = 1'b0;
    pop        = 1'b0;
    word_valid = 1'b0;
    case (state)
      FETCH: begin
        // reset gates pop so the FIFO is never popped while we are held in reset
        pop = !empty && reset;
        if (!empty) begin
          state_nxt = CAPT;
        end
      end
      CAPT: begin
        acc_nxt[idx*SYM_W +: SYM_W] = data_in;
        if (idx == LAST) begin
          state_nxt = HOLD;
          idx_nxt   = '0;
          word_ld   = 1'b1;
        end else begin
          state_nxt = FETCH;
          idx_nxt   = idx + IDX_W'(1);
        end
      end
      HOLD: begin
        word_valid = 1'b1;
        if (word_ready) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // word_out is a separate register so it stays stable while the next word assembles in acc
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      idx      <= '0;
      acc      <= '0;
      word_out <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      acc   <= acc_nxt;
      if (word_ld) begin
        word_out <= acc_nxt;
      end
    end
  end

`ifdef FIFO_RD_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_parity <= 1'b0;
    end else if (word_ld) begin
      word_parity <= ^acc_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-based FIFO model plus a symbol/word scoreboard checked every cycle.
module tb_fifo_reader;
  localparam int SYM_W = 2;
  localparam int SYMS  = 4;
  localparam int WW    = SYM_W * SYMS;

  logic             clk = 1'b0;
  logic             reset, empty, pop, word_valid, word_ready;
  logic [SYM_W-1:0] data_in;
  logic [WW-1:0]    word_out;
`ifdef FIFO_RD_PARITY_EN
  logic             word_parity;
`endif

  int total = 0;
  int bad   = 0;

  // FIFO contents and test controls
  logic [SYM_W-1:0] fq[$];
  bit               stall, rdy;
  int               cyc;

  // reference model: protocol phase plus word assembly by arithmetic
  bit               m_hold, m_pend;
  int               m_cnt;
  logic [WW-1:0]    m_acc, m_last;
  logic [SYM_W-1:0] m_sym;

  logic [WW-1:0]    acc_words[$];
  int               acc_cyc[$];
  int               vld_cycles;

  fifo_reader #(.SYM_W(SYM_W), .SYMS(SYMS)) dut (
    .clk        (clk),
    .reset      (reset),
    .empty      (empty),
    .data_in    (data_in),
    .pop        (pop),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready)
`ifdef FIFO_RD_PARITY_EN
    ,
    .word_parity(word_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic exp_pop;
    logic did_pop;
    @(negedge clk);
    empty      = stall || (fq.size() == 0);
    word_ready = rdy;
    #1;
    exp_pop = !m_hold && !m_pend && !empty;
    chk("pop", pop, exp_pop);
    chk("word_valid", word_valid, m_hold);
    chk("word_out", word_out, m_last);
`ifdef FIFO_RD_PARITY_EN
    chk("word_parity", word_parity, ^m_last);
`endif
    if (word_valid) vld_cycles++;
    if (word_valid && word_ready) begin
      acc_words.push_back(word_out);
      acc_cyc.push_back(cyc);
    end
    if (exp_pop && fq.size() > 0) m_sym = fq[0];
    did_pop = pop;
    @(posedge clk);
    #1;
    if (did_pop && fq.size() > 0) data_in = fq.pop_front();
    if (m_hold && rdy) m_hold = 0;
    if (m_pend) begin
      m_acc = m_acc | (WW'(m_sym) << (SYM_W * m_cnt));
      m_cnt++;
      if (m_cnt == SYMS) begin
        m_hold = 1;
        m_last = m_acc;
        m_acc  = '0;
        m_cnt  = 0;
      end
    end
    m_pend = exp_pop;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    empty = 1'b0;
    #1;
    chk("rst_pop", pop, 1'b0);
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_word", word_out, '0);
    m_hold = 0; m_pend = 0; m_cnt = 0; m_acc = '0; m_last = '0;
    fq.delete();
    stall = 0;
    rdy   = 1;
    empty = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b1;
    acc_words.delete();
    acc_cyc.delete();
    vld_cycles = 0;
    cyc        = 0;
  endtask

  task automatic run_words(input int n, input int budget);
    int start;
    start = acc_words.size();
    for (int i = 0; i < budget && acc_words.size() < start + n; i++) tick();
    chk("word_timeout", 32'(acc_words.size() >= start + n), 1);
  endtask

  initial begin
    reset = 1'b1; empty = 1'b1; word_ready = 1'b0; data_in = '0;
    stall = 0; rdy = 1; cyc = 0; vld_cycles = 0;
    m_hold = 0; m_pend = 0; m_cnt = 0; m_acc = '0; m_last = '0; m_sym = '0;

    // idle after reset: no pops with an empty FIFO
    do_reset();
    for (int i = 0; i < 4; i++) tick();

    // fill and drain
    do_reset();
    fq = '{2'b01, 2'b10, 2'b11, 2'b01};
    run_words(1, 40);
    for (int i = 0; i < 3; i++) tick();
    if (acc_words.size() > 0) begin
      chk("fill_word", acc_words[0], 8'h79);
      chk("fill_cycle", acc_cyc[0], 8);
    end
    chk("fill_vld_len", vld_cycles, 1);

    // backpressure: 5 held cycles, next pop the cycle after acceptance
    do_reset();
    fq = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
    rdy = 0;
    for (int i = 0; i < 13; i++) tick();
    chk("bp_vld_len", vld_cycles, 5);
    rdy = 1;
    run_words(1, 5);
    tick();
    if (acc_words.size() > 0) begin
      chk("bp_word", acc_words[0], 8'h79);
      chk("bp_cycle", acc_cyc[0], 13);
    end

    // empty stall after two symbols
    do_reset();
    fq = '{2'b11, 2'b00};
    for (int i = 0; i < 4; i++) tick();
    stall = 1;
    fq.push_back(2'b10);
    fq.push_back(2'b01);
    for (int i = 0; i < 6; i++) tick();
    chk("stall_fifo_untouched", fq.size(), 2);
    stall = 0;
    run_words(1, 40);
    if (acc_words.size() > 0) chk("stall_word", acc_words[0], 8'h63);

    // back-to-back words
    do_reset();
    fq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    run_words(2, 60);
    if (acc_words.size() > 1) begin
      chk("b2b_word0", acc_words[0], 8'he4);
      chk("b2b_word1", acc_words[1], 8'h1b);
      chk("b2b_gap", acc_cyc[1] - acc_cyc[0], 9);
    end

    // reset mid-word discards captured symbols
    do_reset();
    fq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 20 && m_cnt < 3; i++) tick();
    chk("mid_captured", m_cnt, 3);
    do_reset();
    fq = '{2'b11, 2'b11, 2'b11, 2'b11};
    run_words(1, 40);
    if (acc_words.size() > 0) chk("mid_word", acc_words[0], 8'hff);

    // randomized traffic with a reset in the middle
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      if (fq.size() < 3) fq.push_back(SYM_W'($urandom));
      stall = ($urandom_range(0, 3) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
